// File: rtl/game_pkg.sv
// Shared encodings for the torpedo game: round states, round results and
// the number of cycles the round controller ignores the game timer after starting it.
package game_pkg;

   typedef enum logic [1:0] {
      ST_START  = 2'd0,
      ST_AIM    = 2'd1,
      ST_FLIGHT = 2'd2,
      ST_END    = 2'd3
   } state_t;

   typedef enum logic {
      RESULT_MISS = 1'b0,
      RESULT_HIT  = 1'b1
   } result_t;

   localparam int END_GUARD_CYCLES = 2;

endpackage

// File: rtl/game_round_controller_if.sv
// Sprite, timer and score signals between the round controller and the rest
// of the game top level.
interface game_round_controller_if #(
   parameter int SCORE_WIDTH = 4
);
   logic                   sprite_target_rgb_en;
   logic                   sprite_torpedo_rgb_en;
   logic                   sprite_target_out_of_screen;
   logic                   sprite_torpedo_out_of_screen;
   logic                   end_of_game_timer_running;
   logic                   sprite_target_write;
   logic                   sprite_torpedo_write;
   logic                   end_of_game_timer_start;
   logic                   game_won;
   logic [SCORE_WIDTH-1:0] score_won;
   logic [SCORE_WIDTH-1:0] score_lost;
   logic [1:0]             round_state;

   modport master (
      input  sprite_target_rgb_en, sprite_torpedo_rgb_en,
             sprite_target_out_of_screen, sprite_torpedo_out_of_screen,
             end_of_game_timer_running,
      output sprite_target_write, sprite_torpedo_write, end_of_game_timer_start,
             game_won, score_won, score_lost, round_state
   );

   modport slave (
      output sprite_target_rgb_en, sprite_torpedo_rgb_en,
             sprite_target_out_of_screen, sprite_torpedo_out_of_screen,
             end_of_game_timer_running,
      input  sprite_target_write, sprite_torpedo_write, end_of_game_timer_start,
             game_won, score_won, score_lost, round_state
   );
endinterface

// File: rtl/game_key_sync.sv
// Two-flop synchronizer and rising-edge detector for a raw push button;
// a held button yields a single one-cycle launch pulse.
module game_key_sync (
   input  logic clk,
   input  logic reset,
   input  logic key,
   output logic launch
);
   logic r_sync1, r_sync2, r_sync2_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_sync1   <= 1'b0;
         r_sync2   <= 1'b0;
         r_sync2_d <= 1'b0;
      end else begin
         r_sync1   <= key;
         r_sync2   <= r_sync1;
         r_sync2_d <= r_sync2;
      end
   end

   assign launch = r_sync2 & ~r_sync2_d;
endmodule

// File: rtl/game_round_controller.sv
// Round sequencer for the torpedo game: target launch, torpedo launch on key,
// hit/miss detection with flight timeout, end-of-game timer handshake, scores.
module game_round_controller
   import game_pkg::*;
#(
   parameter int          TIMEOUT_WIDTH  = 26,
   parameter int unsigned FLIGHT_TIMEOUT = 32'h3ffffff,
   parameter int          SCORE_WIDTH    = 4
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    key,
   game_round_controller_if.master bus
);
   localparam logic [TIMEOUT_WIDTH-1:0] CNT_LIMIT   = TIMEOUT_WIDTH'(FLIGHT_TIMEOUT - 1);
   localparam logic [1:0]               END_AGE_MAX = 2'(END_GUARD_CYCLES);

   state_t                   r_state, w_state_nxt;
   logic [3:0]               r_enter, w_enter_nxt;
   logic [TIMEOUT_WIDTH-1:0] r_cnt;
   logic [1:0]               r_end_age;
   logic                     r_won;
   logic [SCORE_WIDTH-1:0]   r_score_won, r_score_lost;
   logic                     w_launch, w_collision, w_guard, w_finish;
   result_t                  w_result;

   game_key_sync u_key_sync (
      .clk    (clk),
      .reset  (reset),
      .key    (key),
      .launch (w_launch)
   );

   assign w_collision = bus.sprite_target_rgb_en & bus.sprite_torpedo_rgb_en;
   // Sprite positions are stale on the first cycle of a state, so ignore out-of-screen then
   assign w_guard     = |r_enter;

   always_comb begin
      w_state_nxt = r_state;
      w_enter_nxt = '0;
      w_finish    = 1'b0;
      w_result    = RESULT_MISS;
      case (r_state)
         ST_START: begin
            // Out of reset START has not been entered yet; take one cycle to do so
            if (r_enter[ST_START]) w_state_nxt = ST_AIM;
            else                   w_enter_nxt[ST_START] = 1'b1;
         end
         ST_AIM: begin
            if (w_launch)
               w_state_nxt = ST_FLIGHT;
            else if (!w_guard && bus.sprite_target_out_of_screen)
               w_finish = 1'b1;
         end
         ST_FLIGHT: begin
            if (w_collision) begin
               w_finish = 1'b1;
               w_result = RESULT_HIT;
            end else if (!w_guard && (bus.sprite_target_out_of_screen ||
                                      bus.sprite_torpedo_out_of_screen)) begin
               w_finish = 1'b1;
            end else if (r_cnt == CNT_LIMIT) begin
               w_finish = 1'b1;
            end
         end
         ST_END: begin
            if (r_end_age == END_AGE_MAX && !bus.end_of_game_timer_running)
               w_state_nxt = ST_START;
         end
         default: w_state_nxt = ST_START;
      endcase
      if (w_finish) w_state_nxt = ST_END;
      if (w_state_nxt != r_state) w_enter_nxt[w_state_nxt] = 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_START;
         r_enter      <= '0;
         r_cnt        <= '0;
         r_end_age    <= '0;
         r_won        <= 1'b0;
         r_score_won  <= '0;
         r_score_lost <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_enter <= w_enter_nxt;
         // Counter restarts whenever the torpedo is (re)launched
         if (r_state != ST_FLIGHT) r_cnt <= '0;
         else                      r_cnt <= r_cnt + 1'b1;
         if (r_state != ST_END)            r_end_age <= '0;
         else if (r_end_age != END_AGE_MAX) r_end_age <= r_end_age + 1'b1;
         if (w_finish)                r_won <= (w_result == RESULT_HIT);
         else if (r_state == ST_START) r_won <= 1'b0;
         if (w_finish && w_result == RESULT_HIT && r_score_won != '1)
            r_score_won <= r_score_won + 1'b1;
         if (w_finish && w_result == RESULT_MISS && r_score_lost != '1)
            r_score_lost <= r_score_lost + 1'b1;
      end
   end

   assign bus.sprite_target_write     = r_enter[ST_START];
   assign bus.sprite_torpedo_write    = r_enter[ST_FLIGHT];
   assign bus.end_of_game_timer_start = r_enter[ST_END];
   assign bus.game_won                = r_won;
   assign bus.score_won               = r_score_won;
   assign bus.score_lost              = r_score_lost;
   assign bus.round_state             = r_state;
endmodule

// File: tb/tb_game_round_controller.sv
// Directed bench for game_round_controller with a round-result scoreboard.
module tb_game_round_controller;
  import game_pkg::*;
  localparam int SW = 4;

  logic clk = 1'b0, reset = 1'b0, key = 1'b0;
  int n_vec = 0, n_err = 0, n_torp = 0;

  typedef struct packed {logic won; logic [SW-1:0] sw; logic [SW-1:0] sl;} res_t;
  res_t sb_q[$];

  game_round_controller_if #(.SCORE_WIDTH(SW)) bus();

  game_round_controller #(
    .TIMEOUT_WIDTH(26), .FLIGHT_TIMEOUT(16), .SCORE_WIDTH(SW)
  ) dut (.clk(clk), .reset(reset), .key(key), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_round(input logic won, input int sw, input int sl);
    res_t r;
    r.won = won; r.sw = SW'(sw); r.sl = SW'(sl);
    sb_q.push_back(r);
  endtask

  task automatic press();
    key = 1'b1;
    tick(2);
    chk("launch_latency", {30'd0, bus.sprite_torpedo_write, bus.round_state == ST_FLIGHT}, 32'd0);
    tick();
    chk("torp_write", {bus.sprite_torpedo_write, bus.round_state}, {1'b1, ST_FLIGHT});
    key = 1'b0;
  endtask

  // Round results, pulse exclusivity and torpedo-launch count
  always @(negedge clk) begin
    if (reset) begin
      if (bus.sprite_target_write + bus.sprite_torpedo_write + bus.end_of_game_timer_start > 1)
        chk("pulse_onehot", 32'd1, 32'd0);
      if (bus.sprite_torpedo_write) n_torp++;
      if (bus.end_of_game_timer_start) begin
        if (sb_q.size() == 0) chk("sb_unexpected_round", 32'd1, 32'd0);
        else chk("sb_round", {23'd0, bus.game_won, bus.score_won, bus.score_lost}, 32'(sb_q.pop_front()));
      end
    end
  end

  initial begin
    bus.sprite_target_rgb_en = 1'b0;         bus.sprite_torpedo_rgb_en = 1'b0;
    bus.sprite_target_out_of_screen = 1'b0;  bus.sprite_torpedo_out_of_screen = 1'b0;
    bus.end_of_game_timer_running = 1'b0;

    // Reset release
    tick(5);
    chk("reset_outs", {bus.sprite_target_write, bus.sprite_torpedo_write, bus.end_of_game_timer_start,
                       bus.game_won, bus.score_won, bus.score_lost, bus.round_state}, 32'd0);
    reset = 1'b1;
    tick();
    chk("rel_target_write", {bus.sprite_target_write, bus.round_state}, {1'b1, ST_START});
    chk("rel_other_outs", {bus.sprite_torpedo_write, bus.end_of_game_timer_start, bus.game_won,
                           bus.score_won, bus.score_lost}, 32'd0);
    tick();
    chk("aim_entry", {bus.sprite_target_write, bus.round_state}, {1'b0, ST_AIM});

    // Out-of-screen on the AIM entry cycle is ignored
    bus.sprite_target_out_of_screen = 1'b1;
    tick();
    chk("aim_guard", bus.round_state, ST_AIM);
    bus.sprite_target_out_of_screen = 1'b0;

    // Hit round, key then held ~100 cycles
    push_round(1'b1, 1, 0);
    key = 1'b1;
    tick(2);
    chk("hit_latency", {bus.sprite_torpedo_write, bus.round_state}, {1'b0, ST_AIM});
    tick();
    chk("hit_torp_write", {bus.sprite_torpedo_write, bus.round_state}, {1'b1, ST_FLIGHT});
    tick(4);
    bus.sprite_target_rgb_en = 1'b1; bus.sprite_torpedo_rgb_en = 1'b1;
    tick();
    bus.sprite_target_rgb_en = 1'b0; bus.sprite_torpedo_rgb_en = 1'b0;
    chk("hit_end", {bus.end_of_game_timer_start, bus.game_won, bus.score_won, bus.round_state},
        {1'b1, 1'b1, 4'd1, ST_END});
    tick();
    chk("timer_start_1cyc", {bus.end_of_game_timer_start, bus.round_state}, {1'b0, ST_END});
    tick();
    chk("end_hold", {bus.game_won, bus.round_state}, {1'b1, ST_END});
    tick();
    chk("restart", {bus.sprite_target_write, bus.round_state}, {1'b1, ST_START});
    tick();
    chk("won_cleared", {bus.game_won, bus.round_state}, {1'b0, ST_AIM});
    tick(87);
    chk("key_hold_state", bus.round_state, ST_AIM);
    chk("key_hold_one_launch", n_torp, 1);
    key = 1'b0;
    tick(3);

    // Collision beats torpedo out-of-screen; then timer busy for 20 cycles
    press();
    push_round(1'b1, 2, 0);
    tick();
    bus.sprite_target_rgb_en = 1'b1; bus.sprite_torpedo_rgb_en = 1'b1;
    bus.sprite_torpedo_out_of_screen = 1'b1;
    tick();
    bus.sprite_target_rgb_en = 1'b0; bus.sprite_torpedo_rgb_en = 1'b0;
    bus.sprite_torpedo_out_of_screen = 1'b0;
    chk("priority", {bus.score_won, bus.score_lost, bus.round_state}, {4'd2, 4'd0, ST_END});
    bus.end_of_game_timer_running = 1'b1;
    tick(20);
    chk("timer_busy", bus.round_state, ST_END);
    bus.end_of_game_timer_running = 1'b0;
    tick();
    chk("timer_done", bus.round_state, ST_START);
    tick();

    // Timeout miss: END exactly 16 cycles after the torpedo write
    press();
    push_round(1'b0, 2, 1);
    tick(15);
    chk("pre_timeout", bus.round_state, ST_FLIGHT);
    tick();
    chk("timeout", {bus.game_won, bus.score_lost, bus.round_state}, {1'b0, 4'd1, ST_END});
    tick(3);
    chk("timeout_restart", bus.round_state, ST_START);
    tick();

    // 20 target-escape losses saturate score_lost
    for (int i = 0; i < 20; i++) begin
      push_round(1'b0, 2, (i + 2 > 15) ? 15 : i + 2);
      bus.sprite_target_out_of_screen = 1'b1;
      tick(2);
      bus.sprite_target_out_of_screen = 1'b0;
      tick(4);
    end
    chk("sat_state", bus.round_state, ST_AIM);
    chk("sat_lost", {bus.score_won, bus.score_lost}, {4'd2, 4'hf});
    chk("torp_total", n_torp, 3);

    // Asynchronous reset mid-round
    reset = 1'b0;
    #1;
    chk("async_reset", {bus.sprite_target_write, bus.game_won, bus.score_won, bus.score_lost,
                        bus.round_state}, 32'd0);
    chk("sb_drained", sb_q.size(), 0);
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/game_round_controller.md
Name: game_round_controller

Overview:
- Sequences one round of the torpedo game: launches the target sprite, arms and launches the torpedo on a key press, and detects a hit or a miss.
- Starts the end-of-game timer and restarts the round when the timer expires.
- Replaces the free-running restart strobe and the tied-off game_won / timer_start signals in the game top level.
- Sits between the two game_sprite_top instances, game_timer and game_mixer.

Parameters:
- TIMEOUT_WIDTH, 26, width of the in-flight timeout counter.
- FLIGHT_TIMEOUT, 26'h3ffffff, max cycles in ST_FLIGHT before the round is declared lost.
- SCORE_WIDTH, 4, width of the won/lost score counters.

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- key  in  1  raw launch button, active-high, asynchronous to clk.
- sprite_target_rgb_en  in  1  target sprite covers current pixel.
- sprite_torpedo_rgb_en  in  1  torpedo sprite covers current pixel.
- sprite_target_out_of_screen  in  1  target has left the screen.
- sprite_torpedo_out_of_screen  in  1  torpedo has left the screen.
- end_of_game_timer_running  in  1  game_timer busy.
- sprite_target_write  out  1  one-cycle pulse: load and start the target.
- sprite_torpedo_write  out  1  one-cycle pulse: load and launch the torpedo.
- end_of_game_timer_start  out  1  one-cycle pulse to game_timer.
- game_won  out  1  last round ended in a hit.
- score_won  out  SCORE_WIDTH  saturating hit count.
- score_lost  out  SCORE_WIDTH  saturating miss count.
- round_state  out  2  current state, for debug and the mixer.

Behaviour:
- Reset (reset==0, async) applies the following; everything else starts on the first clk edge after release.
  - state=ST_START.
  - All pulses 0, game_won=0, scores=0, timeout counter=0, synchronizer flops=0.
- key path:
  - 2-flop synchronizer, then rising-edge detect: launch = sync & ~sync_d.
  - Latency is 3 cycles from key rise to launch.
  - A held key produces exactly one launch.
- collision = sprite_target_rgb_en & sprite_torpedo_rgb_en, combinational, sampled every cycle.
- States (2-bit encoding):
  - ST_START=0
    - Asserts sprite_target_write for exactly 1 cycle.
    - Clears game_won.
    - Goes to ST_AIM.
  - ST_AIM=1
    - Waits for launch.
    - Out_of_screen inputs are ignored on the first cycle in the state (write-to-position guard); the guard flag is set on entry and cleared after 1 cycle.
    - launch: assert sprite_torpedo_write for 1 cycle, clear the timeout counter, go to ST_FLIGHT.
    - Else, target out_of_screen (after guard): loss, go to ST_END.
    - launch and target out_of_screen in the same cycle: launch wins.
  - ST_FLIGHT=2
    - Timeout counter increments each cycle.
    - Out_of_screen inputs are guarded on the first cycle.
    - Priority per cycle:
      - (1) collision: game_won=1, score_won+1, go to ST_END.
      - (2) torpedo or target out_of_screen: loss.
      - (3) counter==FLIGHT_TIMEOUT-1: loss.
    - Any loss does score_lost+1 and goes to ST_END.
    - launch is ignored in this state.
  - ST_END=3
    - Asserts end_of_game_timer_start for 1 cycle, on the entry cycle only.
    - Ignores end_of_game_timer_running on the entry cycle and on the next cycle (timer start latency).
    - From then on, running==0 returns to ST_START.
    - game_won is held for the whole of ST_END.
    - launch and collision are ignored.
- Scores saturate at all-ones; no wrap.
- All outputs are registered: pulses are decoded from the registered state-entry flag, not from combinational next-state.
- At most one of sprite_target_write / sprite_torpedo_write / end_of_game_timer_start is high in any cycle.
- Reset asserted mid-round: immediate return to reset values; an in-progress pulse is truncated.

Decomposition:
- Shared package game_pkg holds:
  - State encoding constants ST_START/ST_AIM/ST_FLIGHT/ST_END.
  - Round-result encoding (RESULT_HIT, RESULT_MISS).
  - The pulse-guard cycle count.
- One sub-module, game_key_sync: 2-flop synchronizer plus rising-edge detector.
  - Ports: clk, reset, key, launch.
  - Reused later for other buttons.
- The FSM, counters and collision logic stay in game_round_controller.

Test Plan:
All scenarios run with FLIGHT_TIMEOUT=16.
- Reset release:
  - Stimulus: reset low 5 cycles then high.
  - Required: sprite_target_write=1 on exactly the first cycle after release, round_state 0→1, all other outputs 0.
- Hit:
  - Stimulus: key rises in ST_AIM; 3 cycles later sprite_torpedo_write pulses once; round_state=2; 5 cycles later both rgb_en=1 for 1 cycle.
  - Required: next cycle game_won=1, score_won=1, round_state=3, end_of_game_timer_start=1 for 1 cycle.
- Timeout miss:
  - Stimulus: launch, then no collision and no out_of_screen.
  - Required: exactly 16 cycles after the torpedo write, round_state=3, score_lost=1, game_won=0.
- Priority:
  - Stimulus: collision and sprite_torpedo_out_of_screen=1 in the same ST_FLIGHT cycle.
  - Required: hit counted (score_won+1, score_lost unchanged).
- Guard and key:
  - Stimulus: target out_of_screen=1 on the ST_AIM entry cycle only.
  - Required: ignored, state stays 1.
  - Stimulus: key held high 100 cycles.
  - Required: only one torpedo write.
- Timer handshake and saturation:
  - Stimulus: hold running=1 for 20 cycles after end_of_game_timer_start, then 0.
  - Required: ST_START 1 cycle later.
  - Stimulus: force 20 losses.
  - Required: score_lost stays 4'hf.
